// File: rtl/shifter.sv
// Registered 32-bit barrel shifter: SLL / SRA / SRL / pass-through of A by B[4:0].
// Optional macro SHIFTER_WIDE_AMOUNT_EN: any set bit in B[31:5] means a shift of 32 or more.
module shifter (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] out,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ctl0,
  input  logic        ctl1
);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;

  logic [1:0]  op;
  logic [4:0]  amt;
  logic        is_left;
  logic        fill;
  logic        wide;
  logic [31:0] pre;
  logic [31:0] st1, st2, st4, st8, st16;
  logic [31:0] post;
  logic [31:0] shift_res;
  logic [31:0] out_d, out_q;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign op      = {ctl1, ctl0};
  assign amt     = B[4:0];
  assign is_left = (op == OP_SLL);
  // Only SRA replicates the sign; left shifts run reversed through the right path with zero fill.
  assign fill    = (op == OP_SRA) & A[31];

`ifdef SHIFTER_WIDE_AMOUNT_EN
  assign wide = |B[31:5];
`else
  logic unused_b_hi;
  assign unused_b_hi = ^B[31:5];
  assign wide        = 1'b0;
`endif

  assign pre  = is_left ? bit_rev(A) : A;
  assign st1  = amt[0] ? {fill, pre[31:1]}           : pre;
  assign st2  = amt[1] ? {{2{fill}}, st1[31:2]}      : st1;
  assign st4  = amt[2] ? {{4{fill}}, st2[31:4]}      : st2;
  assign st8  = amt[3] ? {{8{fill}}, st4[31:8]}      : st4;
  assign st16 = amt[4] ? {{16{fill}}, st8[31:16]}    : st8;
  assign post = is_left ? bit_rev(st16) : st16;

  always_comb begin
    shift_res = post;
    if (wide) shift_res = {32{fill}};
    out_d = (op == OP_PASS) ? A : shift_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= 32'h0000_0000;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed table, reset/latency sequences, sweep and random vs model.
module tb_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] out;
  logic [31:0] A, B;
  logic        ctl0, ctl1;

  int checks = 0;
  int errors = 0;

  shifter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .out  (out),
    .A    (A),
    .B    (B),
    .ctl0 (ctl0),
    .ctl1 (ctl1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ctl;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[18];

  // Reference: plain SV shift operators on the effective amount.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] ctl);
    logic [31:0] n;
`ifdef SHIFTER_WIDE_AMOUNT_EN
    n = b;
`else
    n = b % 32;
`endif
    case (ctl)
      2'b01:   return a << n;
      2'b10:   return $unsigned($signed(a) >>> n);
      2'b11:   return a >> n;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctl);
    A = a; B = b; {ctl1, ctl0} = ctl;
  endtask

  task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] ctl, input logic [31:0] exp);
    @(negedge clk);
    drive(a, b, ctl);
    @(posedge clk);
    #1;
    check(name, out, exp);
  endtask

  logic [31:0] pats[6];
  logic [31:0] amts[4];
  logic [1:0]  ops[3];

  initial begin
    tbl[0]  = '{32'h0000_0001, 32'd31, 2'b01, 32'h8000_0000};
    tbl[1]  = '{32'h0000_0001, 32'd7,  2'b01, 32'h0000_0080};
    tbl[2]  = '{32'h0000_0001, 32'd1,  2'b01, 32'h0000_0002};
    tbl[3]  = '{32'h0000_0001, 32'd0,  2'b01, 32'h0000_0001};
    tbl[4]  = '{32'h7FFF_FFFF, 32'd7,  2'b01, 32'hFFFF_FF80};
    tbl[5]  = '{32'h8000_0000, 32'd7,  2'b10, 32'hFF00_0000};
    tbl[6]  = '{32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF};
    tbl[7]  = '{32'hFEFF_FFFF, 32'd7,  2'b10, 32'hFFFD_FFFF};
    tbl[8]  = '{32'h7FFF_FFFF, 32'd1,  2'b10, 32'h3FFF_FFFF};
    tbl[9]  = '{32'h8000_0000, 32'd31, 2'b11, 32'h0000_0001};
    tbl[10] = '{32'hFFFF_FFFE, 32'd7,  2'b11, 32'h01FF_FFFF};
    tbl[11] = '{32'h0100_0000, 32'd1,  2'b11, 32'h0080_0000};
    tbl[12] = '{32'h1234_5678, 32'd5,  2'b00, 32'h1234_5678};
    tbl[13] = '{32'hA5A5_A5A5, 32'd31, 2'b01, 32'h8000_0000};
    tbl[14] = '{32'hA5A5_A5A5, 32'd0,  2'b10, 32'hA5A5_A5A5};
`ifdef SHIFTER_WIDE_AMOUNT_EN
    tbl[15] = '{32'h0000_0001, 32'h0000_0021, 2'b01, 32'h0000_0000};
    tbl[16] = '{32'h8000_0000, 32'h0000_0100, 2'b10, 32'hFFFF_FFFF};
    tbl[17] = '{32'hFFFF_FFFF, 32'h8000_0003, 2'b11, 32'h0000_0000};
`else
    tbl[15] = '{32'h0000_0001, 32'h0000_0021, 2'b01, 32'h0000_0002};
    tbl[16] = '{32'h8000_0000, 32'h0000_0100, 2'b10, 32'h8000_0000};
    tbl[17] = '{32'hFFFF_FFFF, 32'h8000_0003, 2'b11, 32'h1FFF_FFFF};
`endif

    rst_n = 1'b0;
    drive(32'hDEAD_BEEF, 32'd3, 2'b01);
    #2;
    check("reset_state", out, 32'h0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      apply($sformatf("table_%0d", i), tbl[i].a, tbl[i].b, tbl[i].ctl, tbl[i].exp);

    // Asynchronous reset mid-cycle discards the captured result.
    apply("pre_reset_value", 32'hF000_000F, 32'd4, 2'b11, 32'h0F00_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", out, 32'h0);

    // Release, then first result appears only after one rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h8000_0000, 32'd1, 2'b11);
    #1;
    check("latency_before_edge", out, 32'h0);
    @(posedge clk);
    #1;
    check("latency_after_edge", out, 32'h4000_0000);

    // Input change between edges must not reach out.
    #2;
    drive(32'h0000_00FF, 32'd4, 2'b01);
    #1;
    check("hold_between_edges", out, 32'h4000_0000);
    @(posedge clk);
    #1;
    check("hold_next_edge", out, 32'h0000_0FF0);

    pats[0] = 32'h8000_0000; pats[1] = 32'h0000_0080; pats[2] = 32'h0000_0001;
    pats[3] = 32'h7FFF_FFFF; pats[4] = 32'hFFFF_FF7F; pats[5] = 32'hFFFF_FFFE;
    amts[0] = 32'd0; amts[1] = 32'd1; amts[2] = 32'd7; amts[3] = 32'd31;
    ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b11;
    for (int o = 0; o < 3; o++)
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < 4; k++)
          apply($sformatf("sweep_op%0d_a%h_b%0d", ops[o], pats[p], amts[k]),
                pats[p], amts[k], ops[o], model(pats[p], amts[k], ops[o]));

    for (int r = 0; r < 300; r++) begin
      logic [31:0] ra, rb;
      logic [1:0]  rc;
      ra = $urandom;
      rb = (r % 2 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      rc = 2'($urandom_range(0, 3));
      apply($sformatf("rand_%0d_a%h_b%h_c%0d", r, ra, rb, rc), ra, rb, rc, model(ra, rb, rc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter.md
# shifter

32-bit registered barrel shifter used as the shift unit of the vALU datapath. It performs logical left, arithmetic right and logical right shifts of operand A by an amount taken from operand B. The operation is selected by two control lines. The result is captured in an output register on each rising clock edge.

## Interface
- No parameters; the data width is fixed at 32 bits and the shift-amount field at 5 bits.
- `clk`  input  1  — single clock; all state updates on its rising edge.
- `rst_n`  input  1  — reset, asynchronous, active-low.
- `out`  output  32  — registered shift result.
- `A`  input  32  — operand to be shifted.
- `B`  input  32  — shift amount; bits [4:0] are the shift count (0–31).
- `ctl0`  input  1  — operation select, bit 0.
- `ctl1`  input  1  — operation select, bit 1.
- Port order: `clk, rst_n, out, A, B, ctl0, ctl1`.

## Operation
- Operation select `{ctl1,ctl0}`:
  - 01 = logical left shift (SLL): zeros fill from the LSB.
  - 10 = arithmetic right shift (SRA): A[31] fills from the MSB.
  - 11 = logical right shift (SRL): zeros fill from the MSB.
  - 00 = pass-through: result = A.
- Shift count n = B[4:0]. The handling of B[31:5] is set by the configuration macro (see Configuration).
- n = 0 returns A unchanged for every operation.
- n = 31:
  - SLL result = {A[0], 31'b0}.
  - SRL result = {31'b0, A[31]}.
  - SRA result = all copies of A[31].
- Implementation: a 5-stage logarithmic barrel shifter with stages of 1, 2, 4, 8 and 16 bits.
  - Right shifts use a shared datapath with a fill bit of A[31] for SRA and 0 for SRL.
  - Left shifts may be implemented by bit-reversing the operand around the right shifter, or with a dedicated left path.
- The shift network is purely combinational. The only state is the 32-bit output register.
- Inputs X or Z propagate as X and need no special handling. Every defined input combination yields a fully defined `out` with no X bits.

## Timing
- Latency is 1 cycle. `out` presents f(A, B, ctl) as sampled at the most recent rising `clk` edge.
- A new operation can be accepted every cycle. There is no handshake and no stall.
- Reset:
  - While `rst_n` = 0, `out` = 32'h0000_0000. This takes effect immediately and is independent of `clk`.
  - Release is synchronous in effect: the first result is captured on the first rising edge with `rst_n` = 1.
- Reset asserted mid-operation discards the pending result. No input value survives reset.
- Changing inputs between clock edges has no effect on `out` until the next rising edge.

## Configuration
- `SHIFTER_WIDE_AMOUNT_EN` defined:
  - If any bit of B[31:5] is 1, the shift is treated as ≥ 32.
  - SLL and SRL then produce 0. SRA produces 32 copies of A[31]. Pass-through is unaffected.
- Not defined: B[31:5] is ignored, so the shift count is B mod 32.

## Test plan
- SLL: A=32'h0000_0001, ctl=01.
  - B=31 → 32'h8000_0000.
  - B=7 → 32'h0000_0080.
  - B=1 → 32'h0000_0002.
  - B=0 → 32'h0000_0001.
  - A=32'h7FFF_FFFF, B=7 → 32'hFFFF_FF80.
- SRA: ctl=10.
  - A=32'h8000_0000, B=7 → 32'hFF00_0000.
  - A=32'h8000_0000, B=31 → 32'hFFFF_FFFF.
  - A=32'hFEFF_FFFF, B=7 → 32'hFFFD_FFFF.
  - A=32'h7FFF_FFFF, B=1 → 32'h3FFF_FFFF.
- SRL: ctl=11.
  - A=32'h8000_0000, B=31 → 32'h0000_0001.
  - A=32'hFFFF_FFFE, B=7 → 32'h01FF_FFFF.
  - A=32'h0100_0000, B=1 → 32'h0080_0000.
- Reset and latency:
  - Drive `rst_n`=0 between clock edges → `out`=0 immediately.
  - Release reset, apply SRL A=32'h8000_0000, B=1 → `out`=32'h4000_0000 after exactly one rising edge, not before.
- Pass-through and upper B bits:
  - ctl=00, A=32'h1234_5678 → 32'h1234_5678.
  - SLL with A=1, B=32'h0000_0021:
    - Macro undefined → 32'h0000_0002.
    - Macro defined → 0.
- Sweep: for each op, A with a single 1 (or single 0) at bits 31, 7 and 0, and B ∈ {0, 1, 7, 31} → result matches a bit-accurate shift model in every case.
